operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 clk  input  1  clock; all state changes on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 in_valid / in_ready  input / output  1 / 1  decoded-instruction handshake; transfer when both are high.
REQ-004 in_rs1, in_rs2, in_rd  input  5 each  source and destination register addresses.
REQ-005 in_use_rs1, in_use_rs2  input  1 each  source operand is required.
REQ-006 in_pc  input  32  instruction tag, passed through unchanged.
REQ-007 rd_addr_a, rd_addr_a_valid  output  5, 1  regfile read request, port A (serves rs1).
REQ-008 rd_data_a, rd_data_a_ack  input  32, 1  regfile port A response.
REQ-009 rd_addr_b, rd_addr_b_valid, rd_data_b, rd_data_b_ack  out/out/in/in  5/1/32/1  port B (serves rs2).
REQ-010 snoop_wr_addr, snoop_wr_data, snoop_wr_valid  input  5, 32, 1  copy of the regfile write port.
REQ-011 out_valid / out_ready  output / input  1 / 1  operand-bundle handshake to execute.
REQ-012 out_rs1_data, out_rs2_data, out_rd, out_pc  output  32/32/5/32  captured operands and pass-through fields.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUT.
REQ-014 in_ready SHALL be high only in IDLE with rd_data_a_ack=0 and rd_data_b_ack=0, so that a stale ack from the previous request is never consumed.
REQ-015 On in_valid&&in_ready, the block SHALL latch rs1, rs2, rd, pc and the use flags, and move IDLE->ISSUE.
REQ-016 A port SHALL issue only when its use flag is 1 and its address is non-zero.
  - A non-issued operand reads as 32'h0.
REQ-017 In ISSUE and WAIT, rd_addr_x SHALL hold the latched address and rd_addr_x_valid SHALL be high for each issued port that has not yet been acknowledged.
REQ-018 ISSUE SHALL last exactly one cycle.
  - ISSUE->WAIT if any port issued; ISSUE->OUT if none issued.
REQ-019 In WAIT, each port SHALL capture rd_data_x on the first edge where rd_data_x_ack=1 and its request is outstanding.
  - Capture sets that port's done flag and drops its valid on the same edge.
  - Port A and port B complete independently.
REQ-020 WAIT->OUT SHALL occur on the edge where the last outstanding port captures.
  - Minimum latency: accept edge to out_valid = 2 cycles with ports issued, 1 cycle with none issued.
REQ-021 Snoop forwarding: if snoop_wr_valid=1 in the ISSUE cycle and snoop_wr_addr equals an issued address, that operand SHALL take snoop_wr_data instead of rd_data_x.
  - Applies to both ports at once if both match.
  - Addresses equal to 0 are never forwarded.
REQ-022 out_valid SHALL be high exactly in OUT; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 OUT->IDLE SHALL occur on out_ready=1.
  - No acceptance in the same cycle; one bundle in flight at most.
REQ-024 in_rs1 == in_rs2 SHALL still issue both ports independently.
REQ-025 All rd_addr_x_valid outputs SHALL be low outside ISSUE/WAIT.
  - Any ack arriving outside WAIT is ignored.

Reset
REQ-026 Reset SHALL force the FSM to IDLE and clear the done and forward flags.
  - Outputs: out_valid=0, rd_addr_a_valid=0, rd_addr_b_valid=0, in_ready=0 during reset.
  - Data and address outputs: 0.
REQ-027 Reset asserted in any state SHALL abort the operation with no output produced.
  - After reset, in_ready rises only once both acks read 0.

Structure
REQ-028 Package riscv_pkg SHALL hold: reg_addr_t (5 bits), word_t (32 bits), the state enum of_state_t, and REG_ZERO=5'd0.
REQ-029 A sub-module rf_read_port SHALL implement one port's request/valid/ack/capture/snoop-forward/done logic.
  - It is instantiated twice; the top level holds the FSM and pass-through registers.

Verification
REQ-030 Regs x3=0x0000_00AA and x4=0x0000_0055; accept rs1=3, rs2=4 with 1-cycle regfile.
  - Expect out_rs1=0xAA, out_rs2=0x55, out_valid 2 cycles after accept.
REQ-031 Accept rs1=0 (use=1) and rs2 unused.
  - Expect no rd_addr_*_valid pulse, out_rs1=0, out_rs2=0, out_valid 1 cycle after accept.
REQ-032 During ISSUE for rs1=5, assert snoop write x5=0xDEAD_BEEF while the regfile still holds 0x1.
  - Expect out_rs1=0xDEADBEEF.
REQ-033 Port B ack delayed 4 cycles beyond port A.
  - Expect valid_a to drop after its ack while valid_b is held until its ack.
  - Expect a single out_valid after both acks, with correct data.
REQ-034 Hold out_ready=0 for 5 cycles with in_valid=1 asserted.
  - Expect out_* stable, in_ready=0 and no new regfile request.
  - After out_ready=1, the next request issues only after both acks read 0.
REQ-035 Assert reset in the WAIT state.
  - Expect next cycle: valids=0, out_valid=0.
  - Expect a following transaction to complete with correct operands.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the operand-fetch stage.
// Holds the register/word types, the fetch FSM state encoding and the x0 address.
package riscv_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } of_state_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // x0 is hardwired to zero, so it never needs a regfile read.
  function automatic logic needs_read(input logic use_flag, input reg_addr_t addr);
    return use_flag && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One regfile read port.
// Covers the request, valid, ack and capture logic, plus snoop forwarding and the done flag.
module rf_read_port
  import riscv_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  reg_addr_t load_addr,
  input  logic      load_use,
  input  logic      issue_phase,
  input  logic      wait_phase,
  input  reg_addr_t snoop_wr_addr,
  input  word_t     snoop_wr_data,
  input  logic      snoop_wr_valid,
  output reg_addr_t rd_addr,
  output logic      rd_addr_valid,
  input  word_t     rd_data,
  input  logic      rd_data_ack,
  output word_t     op_data,
  output logic      issued,
  output logic      done_next
);

  reg_addr_t addr_reg;
  word_t     data_reg;
  logic      issued_reg;
  logic      done_reg;
  logic      fwd_reg;

  logic pending;
  logic capture;
  logic snoop_hit;

  assign pending   = issued_reg && !done_reg;
  assign capture   = wait_phase && pending && rd_data_ack;
  assign snoop_hit = issue_phase && snoop_wr_valid && issued_reg &&
                     (snoop_wr_addr == addr_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg   <= REG_ZERO;
      data_reg   <= '0;
      issued_reg <= 1'b0;
      done_reg   <= 1'b0;
      fwd_reg    <= 1'b0;
    end else if (load) begin
      addr_reg   <= load_addr;
      data_reg   <= '0;
      issued_reg <= needs_read(load_use, load_addr);
      done_reg   <= !needs_read(load_use, load_addr);
      fwd_reg    <= 1'b0;
    end else begin
      // A forwarded value wins over the stale regfile data; the request still completes on its ack.
      if (snoop_hit) begin
        data_reg <= snoop_wr_data;
        fwd_reg  <= 1'b1;
      end
      if (capture) begin
        done_reg <= 1'b1;
        if (!fwd_reg) begin
          data_reg <= rd_data;
        end
      end
    end
  end

  assign rd_addr       = addr_reg;
  assign rd_addr_valid = (issue_phase || wait_phase) && pending;
  assign op_data       = data_reg;
  assign issued        = issued_reg;
  assign done_next     = done_reg || capture;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction and reads up to two source registers.
// Applies snoop forwarding, then presents one operand bundle to execute.
module operand_fetch
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_use_rs1,
  input  logic        in_use_rs2,
  input  logic [31:0] in_pc,
  output logic [4:0]  rd_addr_a,
  output logic        rd_addr_a_valid,
  input  logic [31:0] rd_data_a,
  input  logic        rd_data_a_ack,
  output logic [4:0]  rd_addr_b,
  output logic        rd_addr_b_valid,
  input  logic [31:0] rd_data_b,
  input  logic        rd_data_b_ack,
  input  logic [4:0]  snoop_wr_addr,
  input  logic [31:0] snoop_wr_data,
  input  logic        snoop_wr_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc
);

  of_state_t state_reg;
  reg_addr_t rd_reg;
  word_t     pc_reg;

  logic accept;
  logic issue_phase;
  logic wait_phase;

  // Index 0 serves rs1 on port A, index 1 serves rs2 on port B.
  reg_addr_t  src_addr   [2];
  logic [1:0] src_use;
  reg_addr_t  port_addr  [2];
  logic [1:0] port_valid;
  word_t      port_rdata [2];
  logic [1:0] port_ack;
  word_t      port_op    [2];
  logic [1:0] port_issued;
  logic [1:0] port_done_next;

  // A lingering ack from the previous request must clear before a new one is accepted.
  assign in_ready    = !reset && (state_reg == IDLE) && !rd_data_a_ack && !rd_data_b_ack;
  assign accept      = in_valid && in_ready;
  assign issue_phase = !reset && (state_reg == ISSUE);
  assign wait_phase  = !reset && (state_reg == WAIT);

  assign src_addr[0]   = in_rs1;
  assign src_addr[1]   = in_rs2;
  assign src_use       = {in_use_rs2, in_use_rs1};
  assign port_rdata[0] = rd_data_a;
  assign port_rdata[1] = rd_data_b;
  assign port_ack      = {rd_data_b_ack, rd_data_a_ack};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      rf_read_port u_port (
        .clk            (clk),
        .reset          (reset),
        .load           (accept),
        .load_addr      (src_addr[gi]),
        .load_use       (src_use[gi]),
        .issue_phase    (issue_phase),
        .wait_phase     (wait_phase),
        .snoop_wr_addr  (snoop_wr_addr),
        .snoop_wr_data  (snoop_wr_data),
        .snoop_wr_valid (snoop_wr_valid),
        .rd_addr        (port_addr[gi]),
        .rd_addr_valid  (port_valid[gi]),
        .rd_data        (port_rdata[gi]),
        .rd_data_ack    (port_ack[gi]),
        .op_data        (port_op[gi]),
        .issued         (port_issued[gi]),
        .done_next      (port_done_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rd_reg    <= REG_ZERO;
      pc_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= ISSUE;
            rd_reg    <= in_rd;
            pc_reg    <= in_pc;
          end
        end
        ISSUE:   state_reg <= (|port_issued) ? WAIT : OUT;
        WAIT:    if (&port_done_next) state_reg <= OUT;
        OUT:     if (out_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rd_addr_a       = port_addr[0];
  assign rd_addr_a_valid = port_valid[0];
  assign rd_addr_b       = port_addr[1];
  assign rd_addr_b_valid = port_valid[1];

  assign out_valid    = !reset && (state_reg == OUT);
  assign out_rs1_data = port_op[0];
  assign out_rs2_data = port_op[1];
  assign out_rd       = rd_reg;
  assign out_pc       = pc_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed vectors push expected bundles, a monitor pops on each handshake.
module tb_operand_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_use_rs1 = 1'b0, in_use_rs2 = 1'b0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        rd_addr_a_valid, rd_addr_b_valid;
  logic [31:0] rd_data_a = '0, rd_data_b = '0;
  logic        rd_data_a_ack, rd_data_b_ack;
  logic [4:0]  snoop_wr_addr = '0;
  logic [31:0] snoop_wr_data = '0;
  logic        snoop_wr_valid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rs1_data, out_rs2_data, out_pc;
  logic [4:0]  out_rd;

  logic model_ack_a = 1'b0, model_ack_b = 1'b0;
  logic force_ack_a = 1'b0, force_ack_b = 1'b0;
  assign rd_data_a_ack = model_ack_a | force_ack_a;
  assign rd_data_b_ack = model_ack_b | force_ack_b;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_pc(in_pc),
    .rd_addr_a(rd_addr_a), .rd_addr_a_valid(rd_addr_a_valid),
    .rd_data_a(rd_data_a), .rd_data_a_ack(rd_data_a_ack),
    .rd_addr_b(rd_addr_b), .rd_addr_b_valid(rd_addr_b_valid),
    .rd_data_b(rd_data_b), .rd_data_b_ack(rd_data_b_ack),
    .snoop_wr_addr(snoop_wr_addr), .snoop_wr_data(snoop_wr_data), .snoop_wr_valid(snoop_wr_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_pc(out_pc)
  );

  // Regfile model: ack arrives lat_x cycles after the request is first seen.
  logic [31:0] regs [32];
  int lat_a = 0, lat_b = 0, cnt_a = 0, cnt_b = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_addr_a_valid && !model_ack_a) begin
      if (cnt_a >= lat_a) begin
        model_ack_a <= 1'b1; rd_data_a <= regs[rd_addr_a]; cnt_a <= 0;
      end else cnt_a <= cnt_a + 1;
    end else begin
      model_ack_a <= 1'b0;
      if (!rd_addr_a_valid) cnt_a <= 0;
    end
    if (rd_addr_b_valid && !model_ack_b) begin
      if (cnt_b >= lat_b) begin
        model_ack_b <= 1'b1; rd_data_b <= regs[rd_addr_b]; cnt_b <= 0;
      end else cnt_b <= cnt_b + 1;
    end else begin
      model_ack_b <= 1'b0;
      if (!rd_addr_b_valid) cnt_b <= 0;
    end
  end

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out: got pc=0x%08h expected no bundle", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_rs1", out_rs1_data, mon_e.rs1);
        check("out_rs2", out_rs2_data, mon_e.rs2);
        check("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
        check("out_pc", out_pc, mon_e.pc);
        $display("bundle pc=0x%08h rs1=0x%08h rs2=0x%08h rd=%0d", out_pc, out_rs1_data, out_rs2_data, out_rd);
      end
    end
  end

  int acc_cyc = 0;

  // Called at posedge+1; returns at posedge+1 after the accept edge with snoop (if any) driven.
  task automatic do_accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic [31:0] pc,
                           input logic sn_en, input logic [4:0] sn_addr, input logic [31:0] sn_data,
                           input logic [31:0] e1, input logic [31:0] e2, input logic push);
    bit ok = 0;
    exp_t e;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2; in_pc = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    if (push) begin
      e.rs1 = e1; e.rs2 = e2; e.rd = rd; e.pc = pc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    if (sn_en) begin
      snoop_wr_valid = 1'b1; snoop_wr_addr = sn_addr; snoop_wr_data = sn_data;
    end
  endtask

  // Waits for out_valid, measuring latency from the accept edge and watching the request valids.
  task automatic wait_out(output int lat, output int saw, output int split);
    bit ok = 0;
    lat = -1; saw = 0; split = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 2) snoop_wr_valid = 1'b0;
      if (rd_addr_a_valid || rd_addr_b_valid) saw = 1;
      if (!rd_addr_a_valid && rd_addr_b_valid) split++;
      if (out_valid) begin ok = 1; lat = cyc - acc_cyc; break; end
    end
    snoop_wr_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL out_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic run_vec(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [31:0] pc,
                         input logic sn_en, input logic [4:0] sn_addr, input logic [31:0] sn_data,
                         input logic [31:0] e1, input logic [31:0] e2, input int elat, input int esaw);
    int lat, saw, split;
    do_accept(rs1, rs2, 5'd7, u1, u2, pc, sn_en, sn_addr, sn_data, e1, e2, 1'b1);
    wait_out(lat, saw, split);
    check({name, "_latency"}, 32'(lat), 32'(elat));
    check({name, "_req_seen"}, 32'(saw), 32'(esaw));
    @(posedge clk); #1;
  endtask

  int lat, saw, split, bad;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[3] = 32'h0000_00AA; regs[4] = 32'h0000_0055;
    regs[5] = 32'h0000_0001; regs[6] = 32'h0000_0002; regs[9] = 32'h0000_0099;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_valids", {29'd0, out_valid, rd_addr_a_valid, rd_addr_b_valid}, 32'd0);
    check("rst_data", out_rs1_data | out_rs2_data | out_pc, 32'd0);
    check("rst_addr", {17'd0, out_rd, rd_addr_a, rd_addr_b}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    run_vec("basic",      5'd3, 5'd4, 1, 1, 32'h100, 0, 5'd0, 32'h0,         32'hAA,        32'h55,        2, 1);
    run_vec("x0_unused",  5'd0, 5'd9, 1, 0, 32'h104, 0, 5'd0, 32'h0,         32'h0,         32'h0,         1, 0);
    run_vec("snoop_a",    5'd5, 5'd4, 1, 1, 32'h108, 1, 5'd5, 32'hDEADBEEF,  32'hDEADBEEF,  32'h55,        2, 1);
    run_vec("snoop_both", 5'd6, 5'd6, 1, 1, 32'h10C, 1, 5'd6, 32'h12345678,  32'h12345678,  32'h12345678,  2, 1);
    run_vec("snoop_miss", 5'd3, 5'd4, 1, 1, 32'h110, 1, 5'd8, 32'h0000FFFF,  32'hAA,        32'h55,        2, 1);
    run_vec("snoop_x0",   5'd0, 5'd0, 1, 1, 32'h114, 1, 5'd0, 32'h0000CAFE,  32'h0,         32'h0,         1, 0);
    run_vec("b_only",     5'd9, 5'd4, 0, 1, 32'h118, 0, 5'd0, 32'h0,         32'h0,         32'h55,        2, 1);

    // Port B acknowledged four cycles after port A.
    lat_b = 4;
    do_accept(5'd3, 5'd4, 5'd7, 1, 1, 32'h120, 0, 5'd0, 32'h0, 32'hAA, 32'h55, 1'b1);
    wait_out(lat, saw, split);
    check("skew_latency", 32'(lat), 32'd6);
    check("skew_b_only_cycles", 32'(split), 32'd4);
    @(posedge clk); #1;
    lat_b = 0;

    // Backpressure with a new instruction already waiting.
    out_ready = 1'b0;
    do_accept(5'd3, 5'd4, 5'd2, 1, 1, 32'h200, 0, 5'd0, 32'h0, 32'hAA, 32'h55, 1'b1);
    wait_out(lat, saw, split);
    check("bp_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd3; in_use_rs1 = 1; in_use_rs2 = 1; in_pc = 32'h204;
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || in_ready || rd_addr_a_valid || rd_addr_b_valid ||
          out_rs1_data != 32'hAA || out_rs2_data != 32'h55 || out_pc != 32'h200 || out_rd != 5'd2) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1; force_ack_a = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready || rd_addr_a_valid || rd_addr_b_valid) bad++;
    end
    check("stale_ack_blocks", 32'(bad), 32'd0);
    @(posedge clk); #1; force_ack_a = 1'b0;
    do_accept(5'd5, 5'd6, 5'd3, 1, 1, 32'h204, 0, 5'd0, 32'h0, 32'h1, 32'h2, 1'b1);
    wait_out(lat, saw, split);
    check("after_bp_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Reset while waiting on port B: no bundle may come out.
    lat_b = 10;
    do_accept(5'd3, 5'd4, 5'd5, 1, 1, 32'h300, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk); @(negedge clk);
    check("wait_b_pending", {31'd0, rd_addr_b_valid}, 32'd1);
    reset = 1'b1; #1;
    check("in_reset_outputs", {28'd0, in_ready, out_valid, rd_addr_a_valid, rd_addr_b_valid}, 32'd0);
    @(posedge clk); #1; reset = 1'b0; lat_b = 0;
    @(negedge clk);
    check("post_reset_valids", {29'd0, out_valid, rd_addr_a_valid, rd_addr_b_valid}, 32'd0);
    check("post_reset_data", out_rs1_data | out_rs2_data | out_pc, 32'd0);
    @(posedge clk); #1;
    run_vec("after_reset", 5'd4, 5'd3, 1, 1, 32'h304, 0, 5'd0, 32'h0, 32'h55, 32'hAA, 2, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
